bcd_conv_arbiter: RTL and testbench
===================================

Name: bcd_conv_arbiter

Overview:
Shares one 16-bit binary-to-BCD double-dabble converter among N_REQ requesters (display digits, UART formatter, etc.) with per-requester req/ack handshakes. Performs round-robin arbitration, latches the winner's operand, and sequences the converter's init/done handshake. Returns the 4-digit BCD result with a one-cycle ack to the granted requester. Sits between the converter instance and its clients.

Parameters:
N_REQ, 4, number of requesters (2..8)
GUARD_CYC, 2, cycles after conv_init during which conv_done is ignored (stale-done guard)
TIMEOUT_CYC, 64, converter watchdog limit in cycles (used only with CONV_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
req  in  N_REQ  per-requester request level; held until ack
bin_in  in  16*N_REQ  flattened operands; requester i uses bits [16i+15:16i]; stable while req[i]=1
grant  out  N_REQ  one-hot, current owner of converter
ack  out  N_REQ  one-hot, one-cycle pulse when result is valid
bcd_out  out  16  BCD result {thousands,hundreds,tens,units}, held until next capture
busy  out  1  high in every state except IDLE
err  out  1  result invalid (timeout); valid together with ack
conv_init  out  1  one-cycle start pulse to converter
conv_A  out  16  operand to converter, held from START until capture
conv_C  in  16  converter result
conv_done  in  1  converter done level

Behaviour:
- Reset (rst=0, async): state=IDLE; grant, ack, bcd_out, conv_A, err, conv_init = 0; busy=0; rr_ptr=0; guard/watchdog counters=0.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE: if req!=0, pick the first set bit scanning circularly from rr_ptr; set grant one-hot; latch bin_in slice into conv_A; -> START. Else stay.
- START: conv_init=1 for exactly this cycle; load guard counter with GUARD_CYC; -> WAIT.
- WAIT: decrement guard to 0; conv_done ignored while guard!=0. First cycle with guard==0 and conv_done=1: bcd_out<=conv_C, err<=0; -> RESP.
- RESP: ack[granted]=1 for one cycle; rr_ptr <= (granted index + 1) mod N_REQ; grant cleared at exit; -> IDLE.
- Latency: req seen in IDLE -> ack = 3 + GUARD_CYC + converter time cycles minimum. One conversion in flight at a time; no back-to-back without passing through IDLE.
- req changes or bin_in changes during a grant are ignored (operand latched in IDLE). A req deasserted before ack still completes and acks (ack to a dropped req is legal; requester discards it).
- req still high the cycle after ack is treated as a new request; rr_ptr has already advanced, so other pending requesters win first.
- Simultaneous requests: exactly one granted; with all requests persistent, service order is 0,1,2,…,N_REQ-1,0 (fair within N_REQ conversions).
- Operands >9999 passed through unchanged; result is then converter-defined, no flag.
- Reset mid-operation: immediate return to IDLE, no ack issued, conv_init low; converter state not this block's responsibility.
- conv_done high while in IDLE/START/RESP: ignored.

Optional Feature:
CONV_TIMEOUT_EN: when defined, a watchdog counts cycles in WAIT; if TIMEOUT_CYC reached without conv_done, bcd_out<=16'h0000, err<=1, -> RESP (ack issued normally, rr_ptr advances). err cleared on next successful capture or reset. When undefined: no watchdog, WAIT waits indefinitely, err tied to 0.

Test Plan:
- Single req[0], bin=1234, converter model done after 20 cycles -> one ack[0] pulse, bcd_out=16'h1234, err=0, exactly one conv_init pulse.
- Boundaries: bin=0 -> 16'h0000; bin=9999 -> 16'h9999; each with ack to correct requester.
- req[0] and req[2] asserted same cycle (bin 42, 305), rr_ptr=0 -> ack[0] with 16'h0042 first, then ack[2] with 16'h0305.
- All four req held with bins 1,2,3,4 for 8 conversions -> ack order 0,1,2,3,0,1,2,3, matching bcd_out 0001..0004.
- Stale done: model keeps conv_done=1 from prior conversion for 1 cycle after conv_init -> not captured; correct new value (e.g. 777 -> 16'h0777) captured.
- rst pulled low during WAIT -> all outputs 0 immediately, no ack; with CONV_TIMEOUT_EN, model never asserts done -> after TIMEOUT_CYC ack with err=1, bcd_out=0.

Source files
------------

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin arbiter that shares one 16-bit binary-to-BCD
// converter among N_REQ requesters. The winner's operand is latched in IDLE.
// The converter is started with a one-cycle conv_init pulse. conv_done is
// ignored for GUARD_CYC cycles after the start, so a done level left over
// from the previous conversion cannot be captured. The result is returned
// with a one-cycle ack to the granted requester.
//
// Optional build macro CONV_TIMEOUT_EN adds a converter watchdog. After
// TIMEOUT_CYC cycles in WAIT without conv_done, the block answers with
// bcd_out=0 and err=1. Without the macro, err is tied low and WAIT waits
// indefinitely.
module bcd_conv_arbiter #(
    parameter int N_REQ       = 4,
    parameter int GUARD_CYC   = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  bin_in,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     ack,
    output logic [15:0]          bcd_out,
    output logic                 busy,
    output logic                 err,
    output logic                 conv_init,
    output logic [15:0]          conv_A,
    input  logic [15:0]          conv_C,
    input  logic                 conv_done
);

    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GW   = (GUARD_CYC > 0) ? $clog2(GUARD_CYC + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   rr_ptr_q;
    logic [IDXW-1:0]   idx_q;
    logic [N_REQ-1:0]  grant_q;
    logic [15:0]       conv_a_q;
    logic [15:0]       bcd_q;
    logic [GW-1:0]     guard_q;

    logic              pick_found;
    logic [IDXW-1:0]   pick_idx;
    logic [IDXW-1:0]   scan_idx;
    logic [N_REQ-1:0]  pick_onehot;
    int                scan_j;
    logic              wait_capture;
    logic              wait_timeout;

    // Round-robin scan: first requester at or after rr_ptr, wrapping around
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path holds a stale value and no latch is inferred.
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_j     = 0;
        scan_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_j = int'(rr_ptr_q) + i;
            if (scan_j >= N_REQ) begin
                scan_j = scan_j - N_REQ;
            end
            scan_idx = IDXW'(scan_j);
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    assign pick_onehot  = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;

    // Capture only once the stale-done guard window has fully elapsed
    assign wait_capture = (state_q == S_WAIT) && (guard_q == '0) && conv_done;

`ifdef CONV_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    logic [WW-1:0] wd_q;
    logic          err_q;

    assign wait_timeout = (state_q == S_WAIT) && !wait_capture &&
                          (wd_q == WW'(TIMEOUT_CYC - 1));

    // Watchdog counts WAIT cycles; err reflects how the last conversion ended
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == S_START) begin
                wd_q <= '0;
            end else if (state_q == S_WAIT) begin
                wd_q <= wd_q + WW'(1);
            end
            if (wait_capture) begin
                err_q <= 1'b0;
            end else if (wait_timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    assign wait_timeout = 1'b0;
    assign err          = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pick_found) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (wait_capture || wait_timeout) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: start pulse, ack pulse and busy flag
    always_comb begin
        conv_init = 1'b0;
        ack       = '0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE:  busy = 1'b0;
            S_START: begin
                busy      = 1'b1;
                conv_init = 1'b1;
            end
            S_WAIT:  busy = 1'b1;
            S_RESP:  begin
                busy = 1'b1;
                ack  = grant_q;
            end
            default: busy = 1'b0;
        endcase
    end

    // Datapath: grant/operand latch, guard countdown, result capture, pointer advance
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: this block holds only a handful of registers and no storage array, so every one is reset to a defined value.
        if (!rst) begin
            rr_ptr_q <= '0;
            idx_q    <= '0;
            grant_q  <= '0;
            conv_a_q <= '0;
            bcd_q    <= '0;
            guard_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_found) begin
                        idx_q    <= pick_idx;
                        grant_q  <= pick_onehot;
                        conv_a_q <= bin_in[{pick_idx, 4'b0000} +: 16];
                    end
                end
                S_START: begin
                    guard_q <= GW'(GUARD_CYC);
                end
                S_WAIT: begin
                    if (guard_q != '0) begin
                        guard_q <= guard_q - GW'(1);
                    end
                    if (wait_capture) begin
                        bcd_q <= conv_C;
                    end else if (wait_timeout) begin
                        bcd_q <= '0;
                    end
                end
                S_RESP: begin
                    grant_q  <= '0;
                    rr_ptr_q <= (idx_q == IDXW'(N_REQ - 1)) ? '0 : idx_q + IDXW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign grant   = grant_q;
    assign bcd_out = bcd_q;
    assign conv_A  = conv_a_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Testbench for bcd_conv_arbiter. It applies directed requests with
// hand-computed BCD results. A scoreboard queue holds the expected acks, and
// a monitor pops and compares an entry on every ack pulse. A behavioural
// converter model answers conv_init after a programmable latency. It can also
// hold a stale done level for a few cycles after a new conv_init.
module tb_bcd_conv_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req;
    logic [16*N-1:0] bin_in;
    logic [N-1:0]    grant;
    logic [N-1:0]    ack;
    logic [15:0]     bcd_out;
    logic            busy;
    logic            err;
    logic            conv_init;
    logic [15:0]     conv_A;
    logic [15:0]     conv_C;
    logic            conv_done;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] bcd;
        logic        err;
    } exp_t;

    exp_t sb[$];

    // converter model controls
    int          conv_lat   = 5;
    int          stale_hold = 0;
    bit          never_done = 1'b0;
    logic [15:0] m_a;
    bit          m_busy;
    int          m_hold;
    int          m_cnt;

    int init_cnt = 0;
    int exp_init = 0;
    int pend[N];

    bcd_conv_arbiter #(
        .N_REQ       (N),
        .GUARD_CYC   (2),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .bin_in    (bin_in),
        .grant     (grant),
        .ack       (ack),
        .bcd_out   (bcd_out),
        .busy      (busy),
        .err       (err),
        .conv_init (conv_init),
        .conv_A    (conv_A),
        .conv_C    (conv_C),
        .conv_done (conv_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input logic [15:0] v);
        int x;
        x = int'(v);
        return {4'((x / 1000) % 10), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    // Behavioural converter: done is a level that stays high until the next start
    always @(negedge clk) begin
        if (!rst) begin
            conv_done = 1'b0;
            conv_C    = 16'h0000;
            m_busy    = 1'b0;
            m_hold    = 0;
            m_cnt     = 0;
        end else if (conv_init) begin
            m_a    = conv_A;
            m_busy = 1'b1;
            m_cnt  = conv_lat;
            m_hold = stale_hold;
            if (m_hold == 0) conv_done = 1'b0;
        end else if (m_busy) begin
            if (m_hold > 0) begin
                m_hold--;
                if (m_hold == 0) conv_done = 1'b0;
            end else if (!never_done) begin
                if (m_cnt > 1) begin
                    m_cnt--;
                end else begin
                    conv_done = 1'b1;
                    conv_C    = to_bcd(m_a);
                    m_busy    = 1'b0;
                end
            end
        end
    end

    // Start-pulse counter: a pulse longer than one cycle counts more than once
    always @(negedge clk) begin
        if (conv_init === 1'b1) init_cnt++;
    end

    // Scoreboard monitor: every ack pulse consumes one expected entry
    always @(negedge clk) begin
        if (rst === 1'b1 && ack !== '0) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(ack), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_onehot", 32'(ack), 32'(4'b0001 << e.idx));
                check("grant_at_ack", 32'(grant), 32'(4'b0001 << e.idx));
                check("bcd_out", 32'(bcd_out), 32'(e.bcd));
                check("err", 32'(err), 32'(e.err));
            end
        end
    end

    task automatic push(input int idx, input logic [15:0] bcd, input logic e);
        exp_t x;
        x.idx = 2'(idx);
        x.bcd = bcd;
        x.err = e;
        sb.push_back(x);
    endtask

    task automatic set_bin(input int i, input logic [15:0] v);
        bin_in[i*16 +: 16] = v;
    endtask

    function automatic bit any_pend();
        bit r;
        r = 1'b0;
        for (int i = 0; i < N; i++) if (pend[i] != 0) r = 1'b1;
        return r;
    endfunction

    // Raise req for the masked requesters; each drops req after 'count' acks
    task automatic serve(input logic [N-1:0] mask, input int count, input int budget);
        int n;
        n = 0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                pend[i] = count;
                req[i]  = 1'b1;
            end
        end
        while ((any_pend() || busy) && n < budget) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (ack[i] && pend[i] > 0) begin
                    pend[i]--;
                    if (pend[i] == 0) req[i] = 1'b0;
                end
            end
            n++;
        end
        check("serve_within_budget", 32'(n < budget), 32'h1);
        check("conv_init_count", 32'(init_cnt), 32'(exp_init));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'h0);
        check({tag, "_ack"}, 32'(ack), 32'h0);
        check({tag, "_bcd_out"}, 32'(bcd_out), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_err"}, 32'(err), 32'h0);
        check({tag, "_conv_init"}, 32'(conv_init), 32'h0);
        check({tag, "_conv_A"}, 32'(conv_A), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        req    = '0;
        bin_in = '0;
        for (int i = 0; i < N; i++) pend[i] = 0;

        // reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // single request, slow converter
        conv_lat = 20;
        set_bin(0, 16'd1234);
        push(0, 16'h1234, 1'b0);
        exp_init += 1;
        serve(4'b0001, 1, 500);
        conv_lat = 5;

        // boundaries: 0 on requester 1, 9999 on requester 3
        set_bin(1, 16'd0);
        push(1, 16'h0000, 1'b0);
        exp_init += 1;
        serve(4'b0010, 1, 500);
        set_bin(3, 16'd9999);
        push(3, 16'h9999, 1'b0);
        exp_init += 1;
        serve(4'b1000, 1, 500);

        // simultaneous requests 0 and 2 with rr_ptr back at 0
        set_bin(0, 16'd42);
        set_bin(2, 16'd305);
        push(0, 16'h0042, 1'b0);
        push(2, 16'h0305, 1'b0);
        exp_init += 2;
        serve(4'b0101, 1, 500);

        // stale done from the previous conversion held across the guard window
        stale_hold = 3;
        set_bin(3, 16'd777);
        push(3, 16'h0777, 1'b0);
        exp_init += 1;
        serve(4'b1000, 1, 500);
        stale_hold = 0;

        // all four persistent: fair order 0,1,2,3,0,1,2,3
        for (int i = 0; i < N; i++) set_bin(i, 16'(i + 1));
        for (int r = 0; r < 2; r++) begin
            push(0, 16'h0001, 1'b0);
            push(1, 16'h0002, 1'b0);
            push(2, 16'h0003, 1'b0);
            push(3, 16'h0004, 1'b0);
        end
        exp_init += 8;
        serve(4'b1111, 2, 2000);

        // reset asserted while waiting on the converter: no ack may follow
        conv_lat = 30;
        set_bin(1, 16'd55);
        req[1] = 1'b1;
        n = 0;
        while (conv_init !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_reset_start_seen", 32'(n < 50), 32'h1);
        exp_init += 1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("mid_reset");
        req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("post_reset_idle_busy", 32'(busy), 32'h0);
        check("post_reset_init_count", 32'(init_cnt), 32'(exp_init));
        conv_lat = 5;

`ifdef CONV_TIMEOUT_EN
        // converter never answers: watchdog acks with err=1 and zero result
        never_done = 1'b1;
        set_bin(2, 16'd123);
        push(2, 16'h0000, 1'b1);
        exp_init += 1;
        serve(4'b0100, 1, 500);
        never_done = 1'b0;

        // next good conversion clears err
        set_bin(0, 16'd5);
        push(0, 16'h0005, 1'b0);
        exp_init += 1;
        serve(4'b0001, 1, 500);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
